l2_home_responder: RTL and testbench

Memory-side responder for the L2 request channel: accepts L2 coherence requests (GETS/GETM/PUTS/PUTM) and returns the matching response (EDATA/DATA/PUTACK) on the L2 response-in channel. It sits where the LLC/directory normally sits and is used for single-L2 bring-up and L2 unit benches. It holds a small line-granular backing store plus one ownership bit per line. It processes one request at a time.

---
 rtl/l2_home_responder.sv | 192 +++++++++++++++++++
 tb/tb_l2_home_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_home_responder.sv
// l2_home_responder
//
// Memory-side responder for the L2 request channel. It stands in for the
// LLC/directory during single-L2 bring-up and L2 unit benches. It keeps a
// small line-granular backing store and one ownership bit per line, and it
// handles one request at a time.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. The source holds valid and its payload stable until
// that edge. ready may depend on internal state but never on valid.
//   request  channel: req_valid  / req_ready  (ready only in IDLE)
//   response channel: rsp_valid  / rsp_ready  (valid only in RSP)
//
// Optional feature macro: HOME_RSP_DELAY_EN
//   Adds the delay_cfg input and a WAIT state. The response is then delayed
//   by delay_cfg extra cycles.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid/ready request handshake
//   req_coh_msg     GETS=0, GETM=1, PUTS=2, PUTM=3
//   req_hprot       not used by the responder
//   req_addr        line address; the low DEPTH_LOG2 bits index the store
//   req_line        writeback data (PUTM only)
//   rsp_valid/ready response handshake
//   rsp_coh_msg     DATA=0, EDATA=1, PUTACK=3
//   rsp_addr        echo of the accepted request address
//   rsp_line        line data; zero for PUTACK
//   rsp_invack_cnt  always 0 (single sharer)
//   proto_err       sticky protocol-error flag, cleared only by rst
//   delay_cfg       extra response delay (HOME_RSP_DELAY_EN only)
//   req_cnt         accepted-request count, saturating at 16'hFFFF
module l2_home_responder #(
  parameter int LINE_BITS      = 128,
  parameter int LINE_ADDR_BITS = 28,
  parameter int DEPTH_LOG2     = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_coh_msg,
  input  logic                      req_hprot,
  input  logic [LINE_ADDR_BITS-1:0] req_addr,
  input  logic [LINE_BITS-1:0]      req_line,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [1:0]                rsp_coh_msg,
  output logic [LINE_ADDR_BITS-1:0] rsp_addr,
  output logic [LINE_BITS-1:0]      rsp_line,
  output logic [3:0]                rsp_invack_cnt,
  output logic                      proto_err,
`ifdef HOME_RSP_DELAY_EN
  input  logic [3:0]                delay_cfg,
`endif
  output logic [15:0]               req_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] REQ_GETS = 2'd0;
  localparam logic [1:0] REQ_PUTM = 2'd3;

  localparam logic [1:0] RSP_DATA   = 2'd0;
  localparam logic [1:0] RSP_EDATA  = 2'd1;
  localparam logic [1:0] RSP_PUTACK = 2'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
`ifdef HOME_RSP_DELAY_EN
  localparam logic [1:0] WAIT = 2'd2;
`endif
  localparam logic [1:0] RSP  = 2'd3;

  logic [1:0]                state;
  logic [1:0]                msg_q;
  logic [LINE_ADDR_BITS-1:0] addr_q;
  logic [LINE_BITS-1:0]      line_q;
  logic [LINE_BITS-1:0]      mem [DEPTH];
  logic [DEPTH-1:0]          own;
  logic [DEPTH_LOG2-1:0]     idx;
  logic                      req_hs;
  logic                      is_get;
  logic                      own_hit;
  logic                      unused_hprot;
`ifdef HOME_RSP_DELAY_EN
  logic [3:0]                delay_cnt;
`endif

  // Gating with rst keeps req_ready low while reset is held, so it first
  // rises in the cycle after rst deasserts.
  assign req_ready      = (state == IDLE) & ~rst;
  assign rsp_valid      = (state == RSP);
  assign rsp_invack_cnt = 4'd0;
  assign req_hs         = req_valid & req_ready;

  // Addresses that share the low index bits alias onto one entry.
  assign idx     = addr_q[DEPTH_LOG2-1:0];
  assign is_get  = ~msg_q[1];
  assign own_hit = own[idx];

  assign unused_hprot = req_hprot;

  // The backing store is not reset. A PUTM write committed in READ
  // survives a later reset of the rest of the block.
  always_ff @(posedge clk) begin
    if (state == READ && msg_q == REQ_PUTM) begin
      mem[idx] <= line_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      msg_q       <= 2'd0;
      addr_q      <= '0;
      line_q      <= '0;
      own         <= '0;
      rsp_coh_msg <= 2'd0;
      rsp_addr    <= '0;
      rsp_line    <= '0;
      proto_err   <= 1'b0;
      req_cnt     <= 16'd0;
`ifdef HOME_RSP_DELAY_EN
      delay_cnt   <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            msg_q  <= req_coh_msg;
            addr_q <= req_addr;
            line_q <= req_line;
            state  <= READ;
            if (req_cnt != 16'hFFFF) begin
              req_cnt <= req_cnt + 16'd1;
            end
          end
        end
        READ: begin
          rsp_addr <= addr_q;
          if (is_get) begin
            // A GET that finds the line already owned is an error, but the
            // request is still answered.
            rsp_line    <= mem[idx];
            rsp_coh_msg <= (msg_q == REQ_GETS) ? RSP_EDATA : RSP_DATA;
            own[idx]    <= 1'b1;
            if (own_hit) begin
              proto_err <= 1'b1;
            end
          end else begin
            // A PUT from a non-owner is an error, but it is still acked.
            rsp_line    <= '0;
            rsp_coh_msg <= RSP_PUTACK;
            own[idx]    <= 1'b0;
            if (!own_hit) begin
              proto_err <= 1'b1;
            end
          end
`ifdef HOME_RSP_DELAY_EN
          if (delay_cfg != 4'd0) begin
            delay_cnt <= delay_cfg;
            state     <= WAIT;
          end else begin
            state <= RSP;
          end
`else
          state <= RSP;
`endif
        end
`ifdef HOME_RSP_DELAY_EN
        WAIT: begin
          // The counter is loaded with delay_cfg, so the block spends
          // delay_cfg cycles here before entering RSP.
          if (delay_cnt == 4'd1) begin
            state <= RSP;
          end else begin
            delay_cnt <= delay_cnt - 4'd1;
          end
        end
`endif
        RSP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_home_responder.sv
// tb_l2_home_responder
//
// Bench for l2_home_responder. It runs directed scenarios first and then
// randomized requests. Each response is compared with a reference model.
// The model keeps a line array, an ownership array and a sticky error flag,
// and it applies the coherence rules one request at a time.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_l2_home_responder;

  localparam int LB    = 128;
  localparam int AB    = 28;
  localparam int DL    = 6;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_coh_msg = 2'd0;
  logic          req_hprot = 1'b0;
  logic [AB-1:0] req_addr = '0;
  logic [LB-1:0] req_line = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_coh_msg;
  logic [AB-1:0] rsp_addr;
  logic [LB-1:0] rsp_line;
  logic [3:0]    rsp_invack_cnt;
  logic          proto_err;
  logic [15:0]   req_cnt;
`ifdef HOME_RSP_DELAY_EN
  logic [3:0]    delay_cfg = 4'd0;
`endif

  l2_home_responder #(.LINE_BITS(LB), .LINE_ADDR_BITS(AB), .DEPTH_LOG2(DL)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_coh_msg    (req_coh_msg),
    .req_hprot      (req_hprot),
    .req_addr       (req_addr),
    .req_line       (req_line),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_coh_msg    (rsp_coh_msg),
    .rsp_addr       (rsp_addr),
    .rsp_line       (rsp_line),
    .rsp_invack_cnt (rsp_invack_cnt),
    .proto_err      (proto_err),
`ifdef HOME_RSP_DELAY_EN
    .delay_cfg      (delay_cfg),
`endif
    .req_cnt        (req_cnt)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [LB-1:0] mem_m [DEPTH];
  bit            own_m [DEPTH];
  bit            err_m;
  int            cnt_m;
  int            cur_delay = 0;
  int            prev_hs = -100;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [LB-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) own_m[i] = 1'b0;
    err_m = 1'b0;
    cnt_m = 0;
  endtask

  // Apply one request to the model and return the expected response.
  task automatic model_apply(input logic [1:0] msg, input logic [AB-1:0] addr,
                             input logic [LB-1:0] line,
                             output logic [1:0] exp_msg, output logic [LB-1:0] exp_line);
    int i;
    i = int'(addr) % DEPTH;
    if (msg == 2'd0 || msg == 2'd1) begin
      exp_line = mem_m[i];
      exp_msg  = (msg == 2'd0) ? 2'd1 : 2'd0;
      if (own_m[i]) err_m = 1'b1;
      own_m[i] = 1'b1;
    end else begin
      exp_line = '0;
      exp_msg  = 2'd3;
      if (!own_m[i]) err_m = 1'b1;
      if (msg == 2'd3) mem_m[i] = line;
      own_m[i] = 1'b0;
    end
    if (cnt_m < 65535) cnt_m++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check("rst_req_ready", 128'(req_ready), 128'd0);
    repeat (2) @(negedge clk);
    check("rst_req_cnt", 128'(req_cnt), 128'd0);
    check("rst_proto_err", 128'(proto_err), 128'd0);
    check("rst_rsp_line", rsp_line, '0);
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 128'(req_ready), 128'd1);
  endtask

  // ---------------- driver ----------------
  // The task is entered just after a falling edge and leaves at the falling
  // edge of the cycle after the response handshake. The next request can
  // therefore be presented immediately.
  task automatic do_req(input logic [1:0] msg, input logic [AB-1:0] addr,
                        input logic [LB-1:0] line, input int hold,
                        input bit pre_ready, input bit b2b);
    logic [1:0]    exp_msg;
    logic [LB-1:0] exp_line;
    int n, hs;
    model_apply(msg, addr, line, exp_msg, exp_line);
`ifdef HOME_RSP_DELAY_EN
    delay_cfg = 4'(cur_delay);
`endif
    req_coh_msg = msg;
    req_addr    = addr;
    req_line    = line;
    req_hprot   = 1'($urandom);
    req_valid   = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", 128'(req_ready), 128'd1);
    hs = cyc;
    if (b2b) check("req_spacing", 128'(hs - prev_hs), 128'd3);
    prev_hs = hs;
    @(negedge clk);
    req_valid = 1'b0;
    req_line  = rand_line();
    check("busy_req_ready", 128'(req_ready), 128'd0);
    if (pre_ready) rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", 128'(cyc - hs), 128'(2 + cur_delay));
    check("rsp_msg", 128'(rsp_coh_msg), 128'(exp_msg));
    check("rsp_addr", 128'(rsp_addr), 128'(addr));
    check("rsp_line", rsp_line, exp_line);
    check("rsp_invack", 128'(rsp_invack_cnt), 128'd0);
    check("proto_err", 128'(proto_err), 128'(err_m));
    check("req_cnt", 128'(req_cnt), 128'(cnt_m));
    if (!pre_ready) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("hold_valid", 128'(rsp_valid), 128'd1);
        check("hold_msg", 128'(rsp_coh_msg), 128'(exp_msg));
        check("hold_addr", 128'(rsp_addr), 128'(addr));
        check("hold_line", rsp_line, exp_line);
        check("hold_req_ready", 128'(req_ready), 128'd0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 128'(rsp_valid), 128'd0);
    check("post_rsp_req_ready", 128'(req_ready), 128'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [LB-1:0] x_line;
  logic [AB-1:0] r_addr;
  logic [1:0]    d_msg;
  logic [LB-1:0] d_line;
  int            n_wait;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = rand_line();
    end
    mem_m[5] = {4{32'hA5A5_A5A5}};
    for (int i = 0; i < DEPTH; i++) begin
      dut.mem[i] = mem_m[i];
    end
    @(negedge clk);
    do_reset();

    // Preloaded line returned as EDATA.
    do_req(2'd0, 28'h5, '0, 0, 1'b0, 1'b0);
    // Writeback followed by a read of the new data.
    do_req(2'd3, 28'h5, 128'h1234, 0, 1'b0, 1'b0);
    do_req(2'd1, 28'h5, '0, 0, 1'b0, 1'b0);
    do_req(2'd2, 28'h5, '0, 0, 1'b0, 1'b0);
    // Two GETS to the same line, back to back. The second one is an error.
    do_req(2'd0, 28'h7, '0, 0, 1'b1, 1'b0);
    do_req(2'd0, 28'h7, '0, 0, 1'b1, 1'b1);
    // Response stalled for 10 cycles.
    do_req(2'd2, 28'h7, '0, 10, 1'b0, 1'b0);
    // Addresses 0x40 and 0x0 share one entry.
    x_line = rand_line();
    do_req(2'd3, 28'h40, x_line, 0, 1'b0, 1'b0);
    do_req(2'd0, 28'h0, '0, 2, 1'b0, 1'b0);

`ifdef HOME_RSP_DELAY_EN
    cur_delay = 3;
    do_req(2'd1, 28'h9, '0, 0, 1'b0, 1'b0);
    cur_delay = 0;
`endif

    // Reset while a response is pending. Line 9 becomes owned first, and
    // the reset must clear that ownership.
    model_apply(2'd0, 28'h9, '0, d_msg, d_line);
    req_coh_msg = 2'd0;
    req_addr    = 28'h9;
    req_valid   = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_wait = 0;
    while (!rsp_valid && n_wait < 40) begin
      @(negedge clk);
      n_wait++;
    end
    check("midrst_rsp_valid_before", 128'(rsp_valid), 128'd1);
    do_reset();
    // A PUTS to the reset line must be flagged, because ownership was cleared.
    do_req(2'd2, 28'h9, '0, 0, 1'b0, 1'b0);
    check("midrst_err_after_puts", 128'(proto_err), 128'd1);

    // Randomized traffic over a few indices so that lines alias often.
    for (int t = 0; t < 80; t++) begin
      r_addr      = 28'($urandom);
      r_addr[5:0] = 6'($urandom_range(0, 7));
`ifdef HOME_RSP_DELAY_EN
      cur_delay = $urandom_range(0, 4);
`endif
      do_req(2'($urandom_range(0, 3)), r_addr, rand_line(),
             $urandom_range(0, 3), 1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
